// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared types and default timing constants for the push-button event logic.
//
// Contents:
//   button_state_t     - event FSM state encoding (IDLE / PRESSED / LONG_HELD)
//   DEFAULT_TICK_DIV   - system clock cycles per 1 ms tick (100 MHz board clock)
//   DEFAULT_LONG_MS    - hold time in ms before a long press is reported
//   DEFAULT_REPEAT_MS  - ms between auto-repeat events after a long press
// ---------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } button_state_t;

    localparam int DEFAULT_TICK_DIV  = 100000;
    localparam int DEFAULT_LONG_MS   = 800;
    localparam int DEFAULT_REPEAT_MS = 200;

endpackage

// File: rtl/button_event_fsm_if.sv
// ---------------------------------------------------------------------------
// button_event_fsm_if
// Bundles the debounced button level going into the event FSM together with
// the synchronised level and the single-cycle events coming out of it.
//
// Signals:
//   debounced_button - debounced level from the slow_clock DFF chain
//   held             - button level after synchronisation into the clock domain
//   press_pulse      - one-cycle event on press
//   release_pulse    - one-cycle event on release
//   long_pulse       - one-cycle event when the hold reaches the long threshold
//   repeat_pulse     - one-cycle event every repeat period while still held
//
// Modports:
//   master - the side that supplies the button level and consumes events
//   slave  - the event FSM itself
// ---------------------------------------------------------------------------
interface button_event_fsm_if;

    logic debounced_button;
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;

    modport master (
        output debounced_button,
        input  held,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  debounced_button,
        output held,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse
    );

endinterface

// File: rtl/button_event_fsm_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Also used by the display scan logic as its time base.
//
// Ports:
//   clock   - system clock, all logic on posedge
//   reset_n - synchronous, active-low reset; clears the count
//   ms_tick - high for one cycle while the count sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_divider #(
    parameter int TICK_DIV = 100000
) (
    input  logic clock,
    input  logic reset_n,
    output logic ms_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign ms_tick = (count == LAST_COUNT);

    // Count 0..TICK_DIV-1 and wrap; never re-phased by anything but reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (ms_tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/button_event_fsm.sv
// ---------------------------------------------------------------------------
// button_event_fsm
// Turns the debounced push-button level into single-cycle events in the
// system clock domain: press, release, long press and auto-repeat while
// held. Each physical press yields exactly one press/release pair, so the
// mode-select logic downstream can act on the pulses directly.
//
// Parameters:
//   TICK_DIV  - clock cycles per 1 ms tick
//   LONG_MS   - hold time in ms before long_pulse fires
//   REPEAT_MS - ms between repeat_pulse events after long_pulse
//
// Ports:
//   clock   - system clock, all logic on posedge
//   reset_n - synchronous, active-low reset; clears all state and outputs
//   bus     - slave side of button_event_fsm_if (button level in, events out)
// ---------------------------------------------------------------------------
module button_event_fsm
    import button_pkg::*;
#(
    parameter int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int LONG_MS   = DEFAULT_LONG_MS,
    parameter int REPEAT_MS = DEFAULT_REPEAT_MS
) (
    input  logic               clock,
    input  logic               reset_n,
    button_event_fsm_if.slave  bus
);

    localparam int HOLD_W = $clog2(LONG_MS + 1);
    localparam int REP_W  = $clog2(REPEAT_MS + 1);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(LONG_MS);
    localparam logic [REP_W-1:0]  REP_LIMIT  = REP_W'(REPEAT_MS);

    logic sync1;
    logic sync2;
    logic prev;
    logic rise;
    logic fall;
    logic ms_tick;

    button_state_t state;
    button_state_t state_next;

    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic [HOLD_W-1:0] hold_inc;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_next;
    logic [REP_W-1:0]  rep_inc;

    logic press_q;
    logic release_q;
    logic long_q;
    logic repeat_q;
    logic press_d;
    logic release_d;
    logic long_d;
    logic repeat_d;

    // Two-flop synchroniser for the asynchronous button level, plus the
    // previous-value register used for edge detection.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= bus.debounced_button;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clock   (clock),
        .reset_n (reset_n),
        .ms_tick (ms_tick)
    );

    // Neither counter is ever incremented past its limit, so these cannot wrap.
    assign hold_inc = hold_cnt + HOLD_W'(1);
    assign rep_inc  = rep_cnt + REP_W'(1);

    // State, counters and registered event outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            rep_cnt   <= rep_next;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    // Next-state and event decode. A fall is checked before the ms tick, so a
    // release landing on the same cycle as a threshold suppresses the
    // long/repeat event; this also keeps the four events mutually exclusive.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        rep_next   = rep_cnt;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    press_d    = 1'b1;
                    hold_next  = '0;
                    state_next = PRESSED;
                end
            end

            PRESSED: begin
                if (fall) begin
                    release_d  = 1'b1;
                    state_next = IDLE;
                end else if (ms_tick) begin
                    hold_next = hold_inc;
                    if (hold_inc == HOLD_LIMIT) begin
                        long_d     = 1'b1;
                        rep_next   = '0;
                        state_next = LONG_HELD;
                    end
                end
            end

            LONG_HELD: begin
                if (fall) begin
                    release_d  = 1'b1;
                    state_next = IDLE;
                end else if (ms_tick) begin
                    if (rep_inc == REP_LIMIT) begin
                        repeat_d = 1'b1;
                        rep_next = '0;
                    end else begin
                        rep_next = rep_inc;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.held          = sync2;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;

    // Simulation-only guard on the timing parameters.
    always @(posedge clock) begin
        param_check: assert (LONG_MS >= 1 && REPEAT_MS >= 1 && TICK_DIV >= 2)
            else $error("button_event_fsm: need LONG_MS>=1, REPEAT_MS>=1, TICK_DIV>=2");
    end

endmodule

// File: tb/tb_button_event_fsm.sv
// ---------------------------------------------------------------------------
// tb_button_event_fsm
// Directed bench for button_event_fsm with TICK_DIV=4, LONG_MS=5, REPEAT_MS=3.
// A table of per-cycle {reset_n, button, expected outputs} rows covers reset,
// a short press whose release lands on the 5th ms tick, and a 100-cycle hold
// with long press and auto-repeat. Hand-written sequences cover reset while
// in LONG_HELD with the button held, and a toggle-every-cycle burst.
// ---------------------------------------------------------------------------
module tb_button_event_fsm;

    localparam int TB_TICK_DIV  = 4;
    localparam int TB_LONG_MS   = 5;
    localparam int TB_REPEAT_MS = 3;

    // Expected-output bits, ordered {held, press, release, long, repeat}.
    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_H    = 5'b10000;
    localparam logic [4:0] E_P    = 5'b01000;
    localparam logic [4:0] E_RL   = 5'b00100;
    localparam logic [4:0] E_L    = 5'b00010;
    localparam logic [4:0] E_RP   = 5'b00001;

    typedef struct {
        logic       reset_n;
        logic       button;
        logic [4:0] expected;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    int total = 0;
    int bad = 0;

    vec_t vectors[$];

    button_event_fsm_if bus();

    button_event_fsm #(
        .TICK_DIV  (TB_TICK_DIV),
        .LONG_MS   (TB_LONG_MS),
        .REPEAT_MS (TB_REPEAT_MS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Drive inputs, then let one rising edge sample them; outputs are looked
    // at 1 time unit after that edge.
    task automatic apply_stimulus(input logic rst_n, input logic btn);
        reset_n = rst_n;
        bus.debounced_button = btn;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] observed();
        return {bus.held, bus.press_pulse, bus.release_pulse,
                bus.long_pulse, bus.repeat_pulse};
    endfunction

    task automatic check_output(input string name, input logic [4:0] expected);
        logic [4:0] actual;
        actual = observed();
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got {held,press,release,long,repeat}=%b want %b",
                     name, actual, expected);
        end
    endtask

    task automatic check_value(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic add_rows(input int count, input logic rst_n, input logic btn,
                            input logic [4:0] expected);
        vec_t v;
        v.reset_n  = rst_n;
        v.button   = btn;
        v.expected = expected;
        for (int i = 0; i < count; i++) begin
            vectors.push_back(v);
        end
    endtask

    initial begin
        int press_seen;
        int release_seen;
        int long_seen;
        int overlaps;
        logic [4:0] exp_now;

        bus.debounced_button = 1'b0;

        // Row index == edge index. Last reset edge is 2, so the divider hands
        // the FSM an ms tick at every edge e with e % 4 == 2 (6, 10, 14, ...).
        add_rows(3, 1'b0, 1'b0, E_NONE);          // edges 0..2 in reset
        add_rows(50, 1'b1, 1'b0, E_NONE);         // 3..52 quiet after reset
        add_rows(3, 1'b1, 1'b0, E_NONE);          // 53..55

        // Short press: high sampled at 56, low at 76. Ticks at 62..74 bring
        // hold to 4; the 5th tick (edge 78) coincides with the fall.
        add_rows(1, 1'b1, 1'b1, E_NONE);          // 56
        add_rows(1, 1'b1, 1'b1, E_H);             // 57
        add_rows(1, 1'b1, 1'b1, E_H | E_P);       // 58 press
        add_rows(17, 1'b1, 1'b1, E_H);            // 59..75
        add_rows(1, 1'b1, 1'b0, E_H);             // 76
        add_rows(1, 1'b1, 1'b0, E_NONE);          // 77
        add_rows(1, 1'b1, 1'b0, E_RL);            // 78 release wins over long
        add_rows(5, 1'b1, 1'b0, E_NONE);          // 79..83

        // 100-cycle hold, high sampled 84..183. Press at 86, long on the 5th
        // tick at 106, repeats at 118, 130, 142, 154, 166, 178.
        add_rows(1, 1'b1, 1'b1, E_NONE);          // 84
        add_rows(1, 1'b1, 1'b1, E_H);             // 85
        add_rows(1, 1'b1, 1'b1, E_H | E_P);       // 86 press
        add_rows(19, 1'b1, 1'b1, E_H);            // 87..105
        add_rows(1, 1'b1, 1'b1, E_H | E_L);       // 106 long
        for (int k = 0; k < 6; k++) begin
            add_rows(11, 1'b1, 1'b1, E_H);
            add_rows(1, 1'b1, 1'b1, E_H | E_RP);  // 118 + 12k repeat
        end
        add_rows(5, 1'b1, 1'b1, E_H);             // 179..183
        add_rows(1, 1'b1, 1'b0, E_H);             // 184
        add_rows(1, 1'b1, 1'b0, E_NONE);          // 185
        add_rows(1, 1'b1, 1'b0, E_RL);            // 186 release
        add_rows(4, 1'b1, 1'b0, E_NONE);          // 187..190

        for (int i = 0; i < vectors.size(); i++) begin
            apply_stimulus(vectors[i].reset_n, vectors[i].button);
            check_output($sformatf("vec%0d", i), vectors[i].expected);
        end

        // Reach LONG_HELD with the button held, then reset for 3 cycles.
        press_seen = 0;
        long_seen  = 0;
        for (int i = 0; i < 60 && long_seen == 0; i++) begin
            apply_stimulus(1'b1, 1'b1);
            if (bus.press_pulse === 1'b1) press_seen++;
            if (bus.long_pulse === 1'b1) long_seen++;
        end
        check_value("pre_reset_long_seen", long_seen, 1);
        check_value("pre_reset_press_count", press_seen, 1);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1);
            check_output($sformatf("in_reset%0d", i), E_NONE);
        end

        // After reset: held at step 2, press at step 3, long on the 5th tick
        // (divider restarts at 0, ticks at steps 4, 8, 12, 16, 20).
        for (int s = 1; s <= 20; s++) begin
            apply_stimulus(1'b1, 1'b1);
            if (s == 1) exp_now = E_NONE;
            else if (s == 3) exp_now = E_H | E_P;
            else if (s == 20) exp_now = E_H | E_L;
            else exp_now = E_H;
            check_output($sformatf("post_reset_step%0d", s), exp_now);
        end

        // Let go and wait for the release.
        release_seen = 0;
        for (int i = 0; i < 10 && release_seen == 0; i++) begin
            apply_stimulus(1'b1, 1'b0);
            if (bus.release_pulse === 1'b1) release_seen++;
        end
        check_value("post_reset_release_seen", release_seen, 1);

        // Toggle every cycle for 40 cycles: each high sample gives a matched
        // press/release pair, and no two events ever coincide.
        press_seen   = 0;
        release_seen = 0;
        overlaps     = 0;
        for (int i = 0; i < 46; i++) begin
            apply_stimulus(1'b1, (i < 40) ? ((i % 2) == 0) : 1'b0);
            if (bus.press_pulse === 1'b1) press_seen++;
            if (bus.release_pulse === 1'b1) release_seen++;
            if ($countones({bus.press_pulse, bus.release_pulse,
                            bus.long_pulse, bus.repeat_pulse}) > 1) overlaps++;
        end
        check_value("toggle_press_count", press_seen, 20);
        check_value("toggle_release_count", release_seen, 20);
        check_value("toggle_overlaps", overlaps, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
